// File: rtl/wave_pkg.sv
// Shared constants and state encoding for the waveform generate/measure blocks.
package wave_pkg;

    localparam int SAMPLE_W = 8;

    // Mid-code shared with wave_dac so the meter triggers around the DAC midpoint.
    localparam int THRESH_DEF = 128;
    localparam int HYST_DEF   = 8;

    typedef enum logic [1:0] {
        ST_SYNC = 2'd0,
        ST_LOW  = 2'd1,
        ST_HIGH = 2'd2
    } meter_state_e;

    function automatic logic at_or_below(input logic [SAMPLE_W-1:0] s,
                                         input logic [SAMPLE_W-1:0] lvl);
        return (s <= lvl);
    endfunction

    function automatic logic at_or_above(input logic [SAMPLE_W-1:0] s,
                                         input logic [SAMPLE_W-1:0] lvl);
        return (s >= lvl);
    endfunction

endpackage

// File: rtl/wave_minmax.sv
// Running max/min tracker: load restarts both at a sample, update folds a sample in.
module wave_minmax
    import wave_pkg::*;
#(
    parameter int W = SAMPLE_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         load_i,
    input  logic         update_i,
    input  logic [W-1:0] s_i,
    output logic [W-1:0] max_o,
    output logic [W-1:0] min_o
);

    logic [W-1:0] max_q, max_d;
    logic [W-1:0] min_q, min_d;

    always_comb begin
        max_d = max_q;
        min_d = min_q;
        if (load_i) begin
            max_d = s_i;
            min_d = s_i;
        end else if (update_i) begin
            if (s_i > max_q) max_d = s_i;
            if (s_i < min_q) min_d = s_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            max_q <= '0;
            min_q <= '1;
        end else begin
            max_q <= max_d;
            min_q <= min_d;
        end
    end

    assign max_o = max_q;
    assign min_o = min_q;

endmodule

// File: rtl/wave_meter.sv
// Measures period and max/min of a sampled waveform between hysteretic rising crossings.
//   state   | meaning
//   SYNC    | no low seen yet since reset/timeout; rising edges ignored
//   LOW     | last classified sample was low; next high sample is a rising edge
//   HIGH    | last classified sample was high; waiting for a low
module wave_meter
    import wave_pkg::*;
#(
    parameter int THRESH     = THRESH_DEF,
    parameter int HYST       = HYST_DEF,
    parameter int CNT_W      = 16,
    parameter int MAX_PERIOD = 65535
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic [CNT_W-1:0]    period,
    output logic [SAMPLE_W-1:0] vmax,
    output logic [SAMPLE_W-1:0] vmin,
    output logic                meas_valid,
    output logic                timeout,
    output logic                locked
);

    localparam logic [SAMPLE_W-1:0] LO_LVL  = SAMPLE_W'(THRESH - HYST);
    localparam logic [SAMPLE_W-1:0] HI_LVL  = SAMPLE_W'(THRESH + HYST);
    localparam logic [CNT_W-1:0]    CNT_MAX = CNT_W'(MAX_PERIOD);

    meter_state_e         state_q;
    logic [CNT_W-1:0]     cnt_q;
    logic [CNT_W-1:0]     period_q;
    logic [SAMPLE_W-1:0]  vmax_q;
    logic [SAMPLE_W-1:0]  vmin_q;
    logic                 meas_q;
    logic                 to_q;
    logic                 locked_q;

    logic                 is_lo;
    logic                 is_hi;
    logic                 rise;
    logic                 advance;
    logic                 tmo;
    logic [SAMPLE_W-1:0]  run_max;
    logic [SAMPLE_W-1:0]  run_min;

    always_comb begin
        is_lo   = at_or_below(sample_in, LO_LVL);
        is_hi   = at_or_above(sample_in, HI_LVL);
        rise    = sample_valid && is_hi && (state_q == ST_LOW);
        advance = sample_valid && locked_q && !rise;
        // An edge on the terminal sample still produces a measurement.
        tmo     = advance && (cnt_q == CNT_MAX);
    end

    wave_minmax #(.W(SAMPLE_W)) u_minmax (
        .clk      (clk),
        .rst_n    (rst_n),
        .load_i   (rise),
        .update_i (advance),
        .s_i      (sample_in),
        .max_o    (run_max),
        .min_o    (run_min)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_SYNC;
            cnt_q    <= '0;
            period_q <= '0;
            vmax_q   <= '0;
            vmin_q   <= '0;
            meas_q   <= 1'b0;
            to_q     <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            meas_q <= 1'b0;
            to_q   <= 1'b0;
            if (sample_valid) begin
                case (state_q)
                    ST_SYNC: if (is_lo) state_q <= ST_LOW;
                    ST_LOW:  if (is_hi) state_q <= ST_HIGH;
                    ST_HIGH: if (is_lo) state_q <= ST_LOW;
                    default: state_q <= ST_SYNC;
                endcase

                if (rise) begin
                    if (locked_q) begin
                        period_q <= cnt_q;
                        vmax_q   <= run_max;
                        vmin_q   <= run_min;
                        meas_q   <= 1'b1;
                    end
                    locked_q <= 1'b1;
                    cnt_q    <= CNT_W'(1);
                end else if (tmo) begin
                    to_q     <= 1'b1;
                    locked_q <= 1'b0;
                    state_q  <= ST_SYNC;
                    cnt_q    <= '0;
                end else if (advance) begin
                    cnt_q <= cnt_q + 1'b1;
                end
            end
        end
    end

    assign period     = period_q;
    assign vmax       = vmax_q;
    assign vmin       = vmin_q;
    assign meas_valid = meas_q;
    assign timeout    = to_q;
    assign locked     = locked_q;

endmodule
